shift_sequencer: RTL and testbench

Command-driven controller for the `shift_register` datapath block. It accepts one shift job at a time over a valid/ready handshake, drives the register's `ctrl`/`data` inputs through a load-then-shift sequence, and counts shifts. When the job ends it returns the register contents with a one-cycle `done` pulse. It sits between a host/CSR master and a single `shift_register #(.N(N))` instance, and is the only driver of that instance's `ctrl` and `data`.

---
 rtl/shift_sequencer.sv | 104 ++++++++++
 tb/tb_shift_sequencer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// shift_sequencer: accepts one shift job at a time and drives an external
// shift_register through a load-then-shift sequence, returning its contents
// with a one-cycle done pulse.
module shift_sequencer #(
  parameter int N  = 8,
  parameter int CW = $clog2(N) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [N-1:0]  cmd_data,
  input  logic          cmd_dir,
  input  logic          cmd_fill,
  input  logic [CW-1:0] cmd_count,
  output logic [1:0]    sr_ctrl,
  output logic [N-1:0]  sr_data,
  input  logic [N-1:0]  sr_q,
  output logic          busy,
  output logic          done,
  output logic [N-1:0]  result
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  localparam logic [1:0] CTRL_HOLD  = 2'd0;
  localparam logic [1:0] CTRL_RIGHT = 2'd1;
  localparam logic [1:0] CTRL_LEFT  = 2'd2;
  localparam logic [1:0] CTRL_LOAD  = 2'd3;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          dir_q, fill_q;
  logic          accept;
  logic [CW-1:0] count_clamped;

  assign cmd_ready     = (state == IDLE);
  assign busy          = !cmd_ready;
  assign accept        = cmd_valid && cmd_ready;
  // Clamping keeps the shift count within the register width, so a large
  // count with fill=0 simply clears the register.
  assign count_clamped = (cmd_count > CW'(N)) ? CW'(N) : cmd_count;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; SHIFT exits on the edge where the counter reads 1.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = LOAD;
      LOAD:    state_nxt = (cnt != '0) ? SHIFT : DONE;
      SHIFT:   if (cnt <= CW'(1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Job capture, shift counter, and registered outputs. sr_ctrl/sr_data are
  // computed from the state being entered so they line up with that state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      dir_q   <= 1'b0;
      fill_q  <= 1'b0;
      sr_ctrl <= CTRL_HOLD;
      sr_data <= '0;
      result  <= '0;
      done    <= 1'b0;
    end else begin
      done <= (state == DONE);
      if (state == DONE) result <= sr_q;

      if (accept) begin
        cnt    <= count_clamped;
        dir_q  <= cmd_dir;
        fill_q <= cmd_fill;
      end else if (state == SHIFT && cnt != '0) begin
        cnt <= cnt - CW'(1);
      end

      case (state_nxt)
        LOAD: begin
          sr_ctrl <= CTRL_LOAD;
          sr_data <= cmd_data;
        end
        SHIFT: begin
          // Replicating fill makes the serial input correct whichever end
          // the register samples.
          sr_ctrl <= dir_q ? CTRL_LEFT : CTRL_RIGHT;
          sr_data <= {N{fill_q}};
        end
        default: begin
          sr_ctrl <= CTRL_HOLD;
          sr_data <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: behavioural job model checked every cycle,
// directed jobs with literal results, random back-to-back jobs, mid-job reset.
module tb_shift_sequencer;
  localparam int N  = 8;
  localparam int CW = $clog2(N) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [N-1:0]  cmd_data = '0;
  logic          cmd_dir = 1'b0;
  logic          cmd_fill = 1'b0;
  logic [CW-1:0] cmd_count = '0;
  logic [1:0]    sr_ctrl;
  logic [N-1:0]  sr_data;
  logic [N-1:0]  sr_q = '0;
  logic          busy;
  logic          done;
  logic [N-1:0]  result;

  int tests = 0;
  int fails = 0;
  int n_done = 0;
  bit armed = 0;

  shift_sequencer #(.N(N), .CW(CW)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .cmd_dir(cmd_dir), .cmd_fill(cmd_fill),
    .cmd_count(cmd_count), .sr_ctrl(sr_ctrl), .sr_data(sr_data), .sr_q(sr_q),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  // Stand-in for the driven shift_register.
  always @(posedge clk) begin
    case (sr_ctrl)
      2'd1: sr_q <= {sr_data[N-1], sr_q[N-1:1]};
      2'd2: sr_q <= {sr_q[N-2:0], sr_data[0]};
      2'd3: sr_q <= sr_data;
      default: sr_q <= sr_q;
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int clampk(input int c);
    return (c > N) ? N : c;
  endfunction

  // Register contents after loading d and shifting k times, as arithmetic.
  function automatic logic [N-1:0] ref_result(input logic [N-1:0] d, input logic dir,
                                              input logic fill, input int k);
    int m, v;
    m = (1 << N) - 1;
    if (dir) v = ((int'(d) << k) & m) | (fill ? (m >> (N - k)) : 0);
    else     v = (int'(d) >> k) | (fill ? ((m << (N - k)) & m) : 0);
    return v[N-1:0];
  endfunction

  // Job model: j counts cycles since the accept edge (j=1 is the load cycle).
  bit           have_job = 0, pending = 0;
  int           j = 0, k = 0;
  logic [N-1:0] m_data, m_res, m_result = '0;
  logic         m_dir, m_fill;

  always @(negedge clk) begin
    logic [1:0]   e_ctrl;
    logic [N-1:0] e_data;
    logic         e_done, e_ready;
    if (armed) begin
      if (reset) begin
        have_job = 0; pending = 0; m_result = '0;
        chk("rst_ctrl", 32'(sr_ctrl), 0);
        chk("rst_data", 32'(sr_data), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_result", 32'(result), 0);
        chk("rst_ready", 32'(cmd_ready), 1);
        chk("rst_busy", 32'(busy), 0);
      end else begin
        if (pending) begin have_job = 1; j = 1; pending = 0; end
        else if (have_job) j++;
        e_ctrl = 2'd0; e_data = '0; e_done = 0;
        e_ready = !have_job || (j >= k + 3);
        if (have_job && j == 1) begin e_ctrl = 2'd3; e_data = m_data; end
        else if (have_job && j >= 2 && j <= k + 1) begin
          e_ctrl = m_dir ? 2'd2 : 2'd1; e_data = {N{m_fill}};
        end
        if (have_job && j == k + 3) begin e_done = 1; m_result = m_res; n_done++; end
        chk("ctrl", 32'(sr_ctrl), 32'(e_ctrl));
        chk("sr_data", 32'(sr_data), 32'(e_data));
        chk("done", 32'(done), 32'(e_done));
        chk("result", 32'(result), 32'(m_result));
        chk("ready", 32'(cmd_ready), 32'(e_ready));
        chk("busy", 32'(busy), 32'(!e_ready));
        if (e_ready && cmd_valid) begin
          pending = 1;
          k = clampk(int'(cmd_count));
          m_data = cmd_data; m_dir = cmd_dir; m_fill = cmd_fill;
          m_res = ref_result(cmd_data, cmd_dir, cmd_fill, k);
        end
      end
    end
  end

  // Issues one job from idle and checks latency, shift count and literal result.
  task automatic run_job(input string nm, input logic [N-1:0] d, input logic dr,
                         input logic fl, input logic [CW-1:0] c, input logic [N-1:0] exp);
    int cyc, sh, ld;
    bit got;
    @(posedge clk); #1;
    cmd_valid = 1; cmd_data = d; cmd_dir = dr; cmd_fill = fl; cmd_count = c;
    @(posedge clk); #1;
    cmd_valid = 0;
    got = 0; sh = 0; ld = 0; cyc = 0;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(negedge clk);
      if (sr_ctrl == 2'd1 || sr_ctrl == 2'd2) sh++;
      if (sr_ctrl == 2'd3) ld++;
      if (done) begin got = 1; cyc = i; end
    end
    chk({nm, "_done_seen"}, 32'(got), 1);
    if (got) begin
      chk({nm, "_latency"}, 32'(cyc), 32'(clampk(int'(c)) + 3));
      chk({nm, "_result"}, 32'(result), 32'(exp));
      chk({nm, "_shifts"}, 32'(sh), 32'(clampk(int'(c))));
      chk({nm, "_loads"}, 32'(ld), 1);
    end
  endtask

  initial begin
    int base, cyc;
    @(posedge clk); #1 armed = 1;
    repeat (20) @(posedge clk);
    #1 reset = 0;
    repeat (3) @(posedge clk);

    // Pin the reference model against hand-computed values.
    chk("model_a5_r0", 32'(ref_result(8'hA5, 0, 0, 3)), 32'h14);
    chk("model_a5_r1", 32'(ref_result(8'hA5, 0, 1, 3)), 32'hF4);
    chk("model_0f_l1", 32'(ref_result(8'h0F, 1, 1, 4)), 32'hFF);
    chk("model_clear", 32'(ref_result(8'hFF, 0, 0, 8)), 32'h00);

    run_job("j55",  8'h55, 0, 0, 4'd0,  8'h55);
    run_job("ja5f0", 8'hA5, 0, 0, 4'd3, 8'h14);
    run_job("ja5f1", 8'hA5, 0, 1, 4'd3, 8'hF4);
    run_job("j0f",  8'h0F, 1, 1, 4'd4,  8'hFF);
    run_job("jc12", 8'h0F, 0, 0, 4'd12, 8'h00);

    // Back-to-back random jobs with cmd_valid held high.
    base = n_done; cyc = 0;
    while (n_done < base + 100 && cyc < 3000) begin
      @(posedge clk); #1;
      cmd_valid = 1;
      cmd_data  = N'($urandom);
      cmd_dir   = 1'($urandom);
      cmd_fill  = 1'($urandom);
      cmd_count = CW'($urandom_range(0, 15));
      cyc++;
    end
    chk("random_jobs_done", 32'(n_done - base >= 100), 1);
    @(posedge clk); #1 cmd_valid = 0;
    repeat (20) @(posedge clk);

    // Reset in the middle of SHIFT after two shifts.
    @(posedge clk); #1;
    cmd_valid = 1; cmd_data = 8'h3C; cmd_dir = 1; cmd_fill = 0; cmd_count = 4'd6;
    @(posedge clk); #1 cmd_valid = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1;
    #1;
    chk("abort_ctrl", 32'(sr_ctrl), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_ready", 32'(cmd_ready), 1);
    repeat (3) @(posedge clk);
    #1 reset = 0;
    run_job("post_rst", 8'hA5, 0, 0, 4'd3, 8'h14);
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
